// File: rtl/alarm_clock_pkg.sv
// rtl/alarm_clock_pkg.sv - shared state type, BCD limits and BCD increment helper for the alarm clock
package alarm_clock_pkg;

    typedef logic [7:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RINGING  = 2'd1,
        SNOOZING = 2'd2
    } alarm_state_e;

    localparam bcd_t BCD_MAX_MS = 8'h59;
    localparam bcd_t BCD_MAX_HH = 8'h23;

    // Two-digit BCD increment that wraps to 00 after max.
    function automatic bcd_t bcd_inc(input bcd_t v, input bcd_t max);
        if (v == max) begin
            return '0;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter wrapping at MAX, with clear and wrap/carry output
module bcd_mod_counter
    import alarm_clock_pkg::*;
#(
    parameter bcd_t MAX = BCD_MAX_MS
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output bcd_t count_o,
    output bcd_t next_o,
    output logic wrap_o
);

    bcd_t count_q;
    bcd_t count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = bcd_inc(count_q, MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // next_o lets the owner compare against the value about to be loaded.
    assign count_o = count_q;
    assign next_o  = count_d;
    assign wrap_o  = inc_i & ~clr_i & (count_q == MAX);

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - BCD 24h timekeeping, alarm register and ring FSM; SNOOZE_EN adds the snooze state
module time_keeper
    import alarm_clock_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_wave,
    input  logic       adj_time,
    input  logic       adj_alarm,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    input  logic       snooze,
    output logic [7:0] time_hh,
    output logic [7:0] time_mm,
    output logic [7:0] time_ss,
    output logic [7:0] disp_hh,
    output logic [7:0] disp_mm,
    output logic       alarm_ring
);

    localparam logic [5:0] RING_LAST = 6'(RING_SECONDS - 1);

    logic sec_wave_q;
    logic tick_q;
    logic run_tick;
    logic edit_alarm;
    logic match;

    bcd_t ss_q, mm_q, hh_q, al_mm_q, al_hh_q;
    bcd_t ss_next, mm_next, hh_next;
    logic ss_wrap, mm_wrap;
    logic unused_hh_wrap, unused_al_mm_wrap, unused_al_hh_wrap;
    bcd_t unused_al_mm_next, unused_al_hh_next;

    alarm_state_e state_q;
    logic [5:0]   ring_cnt_q;
    logic         alarm_ring_q;

    // Loading sec_wave during reset prevents a false edge on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            sec_wave_q <= sec_wave;
            tick_q     <= 1'b0;
        end else begin
            sec_wave_q <= sec_wave;
            tick_q     <= sec_wave & ~sec_wave_q;
        end
    end

    assign run_tick   = tick_q & ~adj_time;
    assign edit_alarm = adj_alarm & ~adj_time;

    bcd_mod_counter #(.MAX(BCD_MAX_MS)) u_ss (
        .clk(clk), .reset(reset),
        .inc_i(run_tick), .clr_i(adj_time & inc_min),
        .count_o(ss_q), .next_o(ss_next), .wrap_o(ss_wrap)
    );

    bcd_mod_counter #(.MAX(BCD_MAX_MS)) u_mm (
        .clk(clk), .reset(reset),
        .inc_i((run_tick & ss_wrap) | (adj_time & inc_min)), .clr_i(1'b0),
        .count_o(mm_q), .next_o(mm_next), .wrap_o(mm_wrap)
    );

    // mm_wrap only carries while counting; a manual minute wrap never touches hours.
    bcd_mod_counter #(.MAX(BCD_MAX_HH)) u_hh (
        .clk(clk), .reset(reset),
        .inc_i((run_tick & mm_wrap) | (adj_time & inc_hour)), .clr_i(1'b0),
        .count_o(hh_q), .next_o(hh_next), .wrap_o(unused_hh_wrap)
    );

    bcd_mod_counter #(.MAX(BCD_MAX_MS)) u_al_mm (
        .clk(clk), .reset(reset),
        .inc_i(edit_alarm & inc_min), .clr_i(1'b0),
        .count_o(al_mm_q), .next_o(unused_al_mm_next), .wrap_o(unused_al_mm_wrap)
    );

    bcd_mod_counter #(.MAX(BCD_MAX_HH)) u_al_hh (
        .clk(clk), .reset(reset),
        .inc_i(edit_alarm & inc_hour), .clr_i(1'b0),
        .count_o(al_hh_q), .next_o(unused_al_hh_next), .wrap_o(unused_al_hh_wrap)
    );

    assign match = run_tick & alarm_en & (hh_next == al_hh_q) &
                   (mm_next == al_mm_q) & (ss_next == 8'h00);

`ifdef SNOOZE_EN
    localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECONDS - 1);
    logic [8:0] snooze_cnt_q;
`else
    logic unused_snooze;
    assign unused_snooze = snooze | (SNOOZE_SECONDS == 0);
`endif

    // Ack/disable beat timeout, timeout beats snooze; counters run on raw ticks even in adj_time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ring_cnt_q   <= '0;
            alarm_ring_q <= 1'b0;
`ifdef SNOOZE_EN
            snooze_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (match) begin
                        state_q      <= RINGING;
                        ring_cnt_q   <= '0;
                        alarm_ring_q <= 1'b1;
                    end
                end
                RINGING: begin
                    if (alarm_ack || !alarm_en) begin
                        state_q      <= IDLE;
                        alarm_ring_q <= 1'b0;
                    end else if (tick_q && ring_cnt_q == RING_LAST) begin
                        state_q      <= IDLE;
                        alarm_ring_q <= 1'b0;
`ifdef SNOOZE_EN
                    end else if (snooze) begin
                        state_q      <= SNOOZING;
                        snooze_cnt_q <= '0;
                        alarm_ring_q <= 1'b0;
`endif
                    end else if (tick_q) begin
                        ring_cnt_q <= ring_cnt_q + 6'd1;
                    end
                end
`ifdef SNOOZE_EN
                SNOOZING: begin
                    if (alarm_ack || !alarm_en) begin
                        state_q <= IDLE;
                    end else if (tick_q && snooze_cnt_q == SNOOZE_LAST) begin
                        state_q      <= RINGING;
                        ring_cnt_q   <= '0;
                        alarm_ring_q <= 1'b1;
                    end else if (tick_q) begin
                        snooze_cnt_q <= snooze_cnt_q + 9'd1;
                    end
                end
`endif
                default: begin
                    state_q      <= IDLE;
                    alarm_ring_q <= 1'b0;
                end
            endcase
        end
    end

    assign time_hh    = hh_q;
    assign time_mm    = mm_q;
    assign time_ss    = ss_q;
    assign disp_hh    = edit_alarm ? al_hh_q : hh_q;
    assign disp_mm    = edit_alarm ? al_mm_q : mm_q;
    assign alarm_ring = alarm_ring_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - scoreboard bench for time_keeper against a seconds-of-day reference model
module tb_time_keeper;

    localparam int RING = 60;
    localparam int SNZ  = 300;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic sec_wave  = 1'b0;
    logic adj_time  = 1'b0;
    logic adj_alarm = 1'b0;
    logic inc_min   = 1'b0;
    logic inc_hour  = 1'b0;
    logic alarm_en  = 1'b0;
    logic alarm_ack = 1'b0;
    logic snooze    = 1'b0;
    logic [7:0] time_hh, time_mm, time_ss, disp_hh, disp_mm;
    logic alarm_ring;

    time_keeper #(.RING_SECONDS(RING), .SNOOZE_SECONDS(SNZ)) dut (
        .clk(clk), .reset(reset), .sec_wave(sec_wave),
        .adj_time(adj_time), .adj_alarm(adj_alarm),
        .inc_min(inc_min), .inc_hour(inc_hour),
        .alarm_en(alarm_en), .alarm_ack(alarm_ack), .snooze(snooze),
        .time_hh(time_hh), .time_mm(time_mm), .time_ss(time_ss),
        .disp_hh(disp_hh), .disp_mm(disp_mm), .alarm_ring(alarm_ring)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [40:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time as seconds of day, alarm as minutes of day, ring state 0 idle/1 ringing/2 snoozing.
    int tod  = 0;
    int al   = 0;
    int st   = 0;
    int rcnt = 0;
    int scnt = 0;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [40:0] snap();
        int h;
        int m;
        logic [7:0] dh;
        logic [7:0] dm;
        logic ring;
        h = tod / 3600;
        m = (tod / 60) % 60;
        if (adj_alarm && !adj_time) begin
            dh = bcd(al / 60);
            dm = bcd(al % 60);
        end else begin
            dh = bcd(h);
            dm = bcd(m);
        end
        ring = (st == 1) ? 1'b1 : 1'b0;
        return {bcd(h), bcd(m), bcd(tod % 60), ring, dh, dm};
    endfunction

    function automatic void push(input int at, input string tag);
        exp_t e;
        e.at  = at;
        e.v   = snap();
        e.tag = tag;
        sb.push_back(e);
    endfunction

    function automatic void model_tick();
        bit hit;
        hit = 1'b0;
        if (!adj_time) begin
            tod = (tod + 1) % 86400;
            hit = alarm_en && (tod == al * 60);
        end
        if (st == 0) begin
            if (hit) begin
                st   = 1;
                rcnt = 0;
            end
        end else if (st == 1) begin
            rcnt++;
            if (rcnt == RING) st = 0;
        end else begin
            scnt++;
            if (scnt == SNZ) begin
                st   = 1;
                rcnt = 0;
            end
        end
    endfunction

    function automatic void model_inc(input bit mn, input bit hr);
        int h;
        int m;
        int s;
        if (adj_time) begin
            h = tod / 3600;
            m = (tod / 60) % 60;
            s = tod % 60;
            if (mn) begin
                m = (m + 1) % 60;
                s = 0;
            end
            if (hr) h = (h + 1) % 24;
            tod = h * 3600 + m * 60 + s;
        end else if (adj_alarm) begin
            h = al / 60;
            m = al % 60;
            if (mn) m = (m + 1) % 60;
            if (hr) h = (h + 1) % 24;
            al = h * 60 + m;
        end
    endfunction

    initial begin : monitor
        exp_t e;
        logic [40:0] got;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e   = sb.pop_front();
                got = {time_hh, time_mm, time_ss, alarm_ring, disp_hh, disp_mm};
                n_checks++;
                if (e.at != cyc) begin
                    n_fail++;
                    $display("FAIL %s: checked at cycle %0d, required at cycle %0d", e.tag, cyc, e.at);
                end else if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s @cycle %0d: got time %h:%h:%h ring %b disp %h:%h, required time %h:%h:%h ring %b disp %h:%h",
                             e.tag, cyc, got[40:33], got[32:25], got[24:17], got[16], got[15:8], got[7:0],
                             e.v[40:33], e.v[32:25], e.v[24:17], e.v[16], e.v[15:8], e.v[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        sec_wave = 1'b1;
        push(cyc + 1, "tick_latency");
        model_tick();
        push(cyc + 2, "tick");
        @(negedge clk);
        @(negedge clk);
        sec_wave = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input bit mn, input bit hr, input bit ack, input bit snz);
        @(negedge clk);
        inc_min   = mn;
        inc_hour  = hr;
        alarm_ack = ack;
        snooze    = snz;
        model_inc(mn, hr);
        if (ack) st = 0;
`ifdef SNOOZE_EN
        if (snz && st == 1) begin
            st   = 2;
            scnt = 0;
        end
`endif
        push(cyc + 1, ack ? "ack" : (snz ? "snooze" : "inc"));
        @(negedge clk);
        inc_min   = 1'b0;
        inc_hour  = 1'b0;
        alarm_ack = 1'b0;
        snooze    = 1'b0;
    endtask

    task automatic set_lv(input bit at, input bit aa, input bit en);
        @(negedge clk);
        adj_time  = at;
        adj_alarm = aa;
        alarm_en  = en;
        if (!en) st = 0;
        push(cyc + 1, "levels");
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        sec_wave = 1'b1;
        tod = 0; al = 0; st = 0; rcnt = 0; scnt = 0;
        push(cyc + 1, "reset_values");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        push(cyc + 1, "no_tick_after_reset");
        push(cyc + 2, "no_tick_after_reset_2");
        @(negedge clk);
        @(negedge clk);
        sec_wave = 1'b0;
    endtask

    task automatic goto_time(input int h, input int m);
        int nh;
        int nm;
        bit en;
        en = alarm_en;
        set_lv(1'b1, 1'b0, en);
        nh = (h - tod / 3600 + 24) % 24;
        nm = (m - (tod / 60) % 60 + 60) % 60;
        if (nm == 0) nm = 60;
        repeat (nh) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (nm) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        set_lv(1'b0, 1'b0, en);
    endtask

    task automatic set_alarm(input int h, input int m);
        int nh;
        int nm;
        bit en;
        en = alarm_en;
        set_lv(1'b0, 1'b1, en);
        nh = (h - al / 60 + 24) % 24;
        nm = (m - al % 60 + 60) % 60;
        repeat (nh) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (nm) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        set_lv(1'b0, 1'b0, en);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin : driver
        int op;
        repeat (2) @(posedge clk);
        do_reset();

        // Adjust: ticks frozen, 2 minute and 25 hour pulses from midnight.
        set_lv(1'b1, 1'b0, 1'b0);
        ticks(3);
        repeat (2) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (25) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);

        // Full rollover through midnight.
        goto_time(23, 59);
        ticks(60);

        // Alarm match and timeout.
        set_alarm(7, 30);
        goto_time(7, 29);
        set_lv(1'b0, 1'b0, 1'b1);
        ticks(59);
        tick();
        ticks(RING);

        // Ack, disable, disabled at match.
        goto_time(7, 29);
        ticks(60);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(2);
        goto_time(7, 29);
        ticks(60);
        set_lv(1'b0, 1'b0, 1'b0);
        goto_time(7, 29);
        ticks(61);

        // Ringing survives entry into adj_time and still times out.
        set_lv(1'b0, 1'b0, 1'b1);
        goto_time(7, 29);
        ticks(60);
        set_lv(1'b1, 1'b0, 1'b1);
        ticks(RING);
        set_lv(1'b0, 1'b0, 1'b1);

        // Snooze.
        goto_time(7, 29);
        ticks(60);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SNOOZE_EN
        ticks(SNZ);
        ticks(2);
`else
        ticks(2);
`endif
        pulse(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-ring with sec_wave high.
        set_lv(1'b0, 1'b0, 1'b1);
        set_alarm(7, 30);
        goto_time(7, 29);
        ticks(60);
        do_reset();

        // Randomized traffic around a pending alarm.
        goto_time($urandom_range(0, 23), $urandom_range(0, 58));
        ticks($urandom_range(40, 58));
        set_alarm(tod / 3600, (tod / 60) % 60 + 1);
        set_lv(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 250; i++) begin
            op = $urandom_range(0, 15);
            if (op <= 8) begin
                tick();
            end else if (op == 9 || op == 10) begin
                if (adj_time || adj_alarm) begin
                    case ($urandom_range(0, 2))
                        0: pulse(1'b1, 1'b0, 1'b0, 1'b0);
                        1: pulse(1'b0, 1'b1, 1'b0, 1'b0);
                        default: pulse(1'b1, 1'b1, 1'b0, 1'b0);
                    endcase
                end else begin
                    tick();
                end
            end else if (op == 11) begin
                pulse(1'b0, 1'b0, 1'b1, 1'b0);
            end else if (op == 12) begin
                pulse(1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
                set_lv($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
            end
        end

        repeat (4) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
